init_fill: RTL and testbench
============================

# init_fill

Parametrised state-array initialiser for the ARC4 datapath and its successors. On a single `en`/`rdy` handshake it sweeps a write port across addresses 0..DEPTH-1, writing one word per cycle from a selectable pattern: identity, constant, reverse, or identity XOR a key byte. It sits between the top-level controller and the S-memory write port, ahead of the KSA and PRGA blocks. A `stall` input lets the memory arbiter hold the sweep.

## Interface
Parameters:
- ADDR_W, 8, address width
- DATA_W, 8, write-data width
- DEPTH, 256, words to initialise; legal range 1..2**ADDR_W

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- en  in  1  start request; accepted only on a clk edge where `rdy`=1
- rdy  out  1  high while idle and able to accept `en`
- mode  in  2  pattern select, sampled on acceptance: 0 identity, 1 constant, 2 reverse, 3 xor
- fill_val  in  DATA_W  pattern operand, sampled on acceptance
- stall  in  1  write port unavailable this cycle
- addr  out  ADDR_W  write address
- wrdata  out  DATA_W  write data
- wren  out  1  write strobe
- busy_cnt  out  ADDR_W+1  number of words written so far in the current sweep

## Operation
- Clock and reset: one clock domain (`clk`). Reset is synchronous and active-high (`rst`).
- The block has two states, IDLE and FILL.
- IDLE:
  - `rdy`=1 and `wren`=0.
  - `en`=1 at a clk edge latches `mode` into mode_q and `fill_val` into val_q, clears the index i to 0, and moves to FILL.
- FILL:
  - `rdy`=0.
  - `addr` = i[ADDR_W-1:0].
  - `wren` = !`stall`. This is the only combinational input-to-output path.
  - At each clk edge with `stall`=0: if i == DEPTH-1, go to IDLE; otherwise i <= i+1.
  - At each clk edge with `stall`=1, i and all outputs hold.
- Data patterns. Each pattern is computed at ADDR_W+1 width, then zero-extended or truncated to DATA_W.
  - mode 0: wrdata = i.
  - mode 1: wrdata = val_q.
  - mode 2: wrdata = DEPTH-1-i.
  - mode 3: wrdata = i ^ val_q.
- `en` while in FILL is ignored and not queued.
- Changes to `mode` or `fill_val` during FILL have no effect.
- `busy_cnt`:
  - Increments on every completed write (edge with FILL && !`stall`).
  - Cleared on acceptance.
  - Holds its final value (DEPTH) in IDLE until the next acceptance.
- `rst` at any time, including mid-FILL, aborts the sweep. No further writes occur after that edge.

## Timing
- Reset values: state IDLE, `rdy`=1, `wren`=0, `addr`=0, `wrdata`=0, `busy_cnt`=0. i, mode_q and val_q are cleared.
- In IDLE, `addr` and `wrdata` are held at 0.
- Acceptance at edge k:
  - Cycle k+1: first write, addr 0.
  - With no stalls, the last write (addr DEPTH-1) is in cycle k+DEPTH.
  - `rdy` rises in cycle k+DEPTH+1.
  - Total latency DEPTH+1 cycles, plus one cycle per stalled cycle.
- `en` held high continuously: a new sweep is accepted at the first edge `rdy`=1, so there is exactly one IDLE cycle between sweeps.
- DEPTH=1: a single write in cycle k+1, then IDLE.
- DEPTH=2**ADDR_W: i never wraps. The terminal compare uses i == DEPTH-1, not overflow.
- `stall` on the final word: remains in FILL with `wren`=0 and addr DEPTH-1 until `stall` drops.
- `rst` and `en` on the same edge: `rst` wins and `en` is ignored.

## Test plan
- **Identity sweep, defaults.** `rst` 2 cycles, then `en`=1 for 1 cycle with mode 0 -> 256 consecutive writes with addr=wrdata=0..255; `rdy` high again at cycle 257 after acceptance; `busy_cnt`=256.
- **Constant and xor modes.**
  - mode 1, fill_val 0xA5 -> all 256 writes carry 0xA5.
  - mode 3, fill_val 0x0F -> addr 0x10 carries 0x1F and addr 0xFF carries 0xF0.
- **Stalls.** Mode 2, `stall` high at cycles 3-5 and on the final word:
  - `wren`=0 and addr held during each stall;
  - no address skipped or duplicated;
  - total latency 256+1+stall count;
  - addr 0 carries 0xFF.
- **Handshake.** `en` pulsed mid-sweep -> ignored, and `busy_cnt` is unaffected. `en` held high across completion -> exactly one `rdy`=1 cycle, then a new sweep starting at addr 0.
- **Reset mid-operation.** `rst` asserted at write 100 -> next cycle `rdy`=1, `wren`=0, `busy_cnt`=0. A fresh `en` then restarts at addr 0.
- **Parameter corners.** Check the full identity write sequence and latency for each configuration:
  - ADDR_W=4, DATA_W=8, DEPTH=10 -> writes 0..9, `rdy` back at cycle 11.
  - DEPTH=1 -> single write.
  - ADDR_W=8, DATA_W=4 -> identity data truncated (addr 0x1F carries 0xF).

Source files
------------

// File: rtl/init_fill_if.sv
// init_fill_if
// Groups the controller/arbiter-facing signals of the state-array initialiser
// into one bundle.
//   en, mode, fill_val : start request and pattern selection (controller side)
//   stall              : write port unavailable this cycle (arbiter side)
//   rdy                : initialiser idle and able to accept en
//   addr, wrdata, wren : S-memory write port
//   busy_cnt           : words written so far in the current sweep
// The master modport is the controller/arbiter view; the slave modport is the
// initialiser itself.
`timescale 1ns/1ps
interface init_fill_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              en;
    logic              rdy;
    logic [1:0]        mode;
    logic [DATA_W-1:0] fill_val;
    logic              stall;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wrdata;
    logic              wren;
    logic [ADDR_W:0]   busy_cnt;

    modport master (
        output en, mode, fill_val, stall,
        input  rdy, addr, wrdata, wren, busy_cnt
    );

    modport slave (
        input  en, mode, fill_val, stall,
        output rdy, addr, wrdata, wren, busy_cnt
    );
endinterface

// File: rtl/init_fill.sv
// init_fill
// State-array initialiser for the ARC4 S-memory. One en/rdy handshake starts a
// sweep that writes addresses 0..DEPTH-1, one word per unstalled cycle, using
// a pattern chosen at acceptance: identity, constant, reverse or identity XOR
// a key byte.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset; aborts any sweep in progress
//   bus  : init_fill_if slave port (en/rdy/mode/fill_val/stall in,
//          addr/wrdata/wren/busy_cnt out)
// DEPTH must lie in 1..2**ADDR_W.
`timescale 1ns/1ps
module init_fill #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic        clk,
    input  logic        rst,
    init_fill_if.slave  bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    // Index and counter are one bit wider than the address so that a full
    // 2**ADDR_W sweep can be counted; patterns are formed at this width too.
    localparam int IW    = ADDR_W + 1;
    localparam int EXT_W = (DATA_W > IW) ? DATA_W : IW;

    localparam logic [IW-1:0]    LAST   = IW'(DEPTH - 1);
    localparam logic [IW-1:0]    ONE    = IW'(1);
    localparam logic [EXT_W-1:0] LAST_E = EXT_W'(DEPTH - 1);
    localparam logic [EXT_W-1:0] PMASK  = EXT_W'({IW{1'b1}});

    logic [0:0]        state_q, state_d;
    logic [IW-1:0]     i_q, i_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic [IW-1:0]     cnt_q, cnt_d;

    // Pattern word for index idx: built at IW bits (operand truncated to IW
    // bits first), then zero-extended or truncated to DATA_W.
    function automatic logic [DATA_W-1:0] pattern(
        input logic [1:0]        md,
        input logic [IW-1:0]     idx,
        input logic [DATA_W-1:0] v
    );
        logic [EXT_W-1:0] ie;
        logic [EXT_W-1:0] ve;
        logic [EXT_W-1:0] pe;
        ie = EXT_W'(idx);
        ve = EXT_W'(v) & PMASK;
        case (md)
            2'd0:    pe = ie;
            2'd1:    pe = ve;
            2'd2:    pe = LAST_E - ie;
            default: pe = ie ^ ve;
        endcase
        pe = pe & PMASK;
        return DATA_W'(pe);
    endfunction

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        mode_d  = mode_q;
        val_d   = val_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    state_d = FILL;
                    i_d     = '0;
                    cnt_d   = '0;
                    mode_d  = bus.mode;
                    val_d   = bus.fill_val;
                end
            end
            default: begin
                // A stalled cycle holds everything; en is not looked at here.
                if (!bus.stall) begin
                    cnt_d = cnt_q + ONE;
                    // Terminal compare on the index value, never on overflow,
                    // so DEPTH == 2**ADDR_W works without wrapping.
                    if (i_q == LAST) begin
                        state_d = IDLE;
                        i_d     = '0;
                    end else begin
                        i_d = i_q + ONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            mode_q  <= '0;
            val_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            mode_q  <= mode_d;
            val_q   <= val_d;
            cnt_q   <= cnt_d;
        end
    end

    // Address and data are forced to zero while idle; wren is the only
    // output with a combinational path from an input (stall).
    assign bus.rdy      = (state_q == IDLE);
    assign bus.wren     = (state_q == FILL) && !bus.stall;
    assign bus.addr     = (state_q == FILL) ? ADDR_W'(i_q) : '0;
    assign bus.wrdata   = (state_q == FILL) ? pattern(mode_q, i_q, val_q) : '0;
    assign bus.busy_cnt = cnt_q;

endmodule

// File: tb/tb_init_fill.sv
`timescale 1ns/1ps
module tb_init_fill;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       stall = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] fill_val = 8'd0;
    int         sel = 0;

    int tests = 0;
    int fails = 0;
    int cap [256];

    // Per-DUT configuration: a = defaults, b = small depth, c = single word,
    // d = narrow data.
    int aw_t  [4] = '{8, 4, 8, 8};
    int dw_t  [4] = '{8, 8, 8, 4};
    int dep_t [4] = '{256, 10, 1, 256};

    always #5 clk = ~clk;

    init_fill_if #(.ADDR_W(8), .DATA_W(8)) bus_a ();
    init_fill_if #(.ADDR_W(4), .DATA_W(8)) bus_b ();
    init_fill_if #(.ADDR_W(8), .DATA_W(8)) bus_c ();
    init_fill_if #(.ADDR_W(8), .DATA_W(4)) bus_d ();

    assign bus_a.en = en && (sel == 0);
    assign bus_b.en = en && (sel == 1);
    assign bus_c.en = en && (sel == 2);
    assign bus_d.en = en && (sel == 3);
    assign bus_a.mode = mode;
    assign bus_b.mode = mode;
    assign bus_c.mode = mode;
    assign bus_d.mode = mode;
    assign bus_a.fill_val = fill_val;
    assign bus_b.fill_val = fill_val;
    assign bus_c.fill_val = fill_val;
    assign bus_d.fill_val = fill_val[3:0];
    assign bus_a.stall = stall;
    assign bus_b.stall = stall;
    assign bus_c.stall = stall;
    assign bus_d.stall = stall;

    init_fill #(.ADDR_W(8), .DATA_W(8), .DEPTH(256)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    init_fill #(.ADDR_W(4), .DATA_W(8), .DEPTH(10))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    init_fill #(.ADDR_W(8), .DATA_W(8), .DEPTH(1))   dut_c (.clk(clk), .rst(rst), .bus(bus_c));
    init_fill #(.ADDR_W(8), .DATA_W(4), .DEPTH(256)) dut_d (.clk(clk), .rst(rst), .bus(bus_d));

    logic [31:0] o_addr, o_wrdata, o_cnt;
    logic        o_rdy, o_wren;

    always_comb begin
        o_addr = '0; o_wrdata = '0; o_cnt = '0; o_rdy = 1'b0; o_wren = 1'b0;
        case (sel)
            0: begin o_addr = 32'(bus_a.addr); o_wrdata = 32'(bus_a.wrdata); o_cnt = 32'(bus_a.busy_cnt);
                     o_rdy = bus_a.rdy; o_wren = bus_a.wren; end
            1: begin o_addr = 32'(bus_b.addr); o_wrdata = 32'(bus_b.wrdata); o_cnt = 32'(bus_b.busy_cnt);
                     o_rdy = bus_b.rdy; o_wren = bus_b.wren; end
            2: begin o_addr = 32'(bus_c.addr); o_wrdata = 32'(bus_c.wrdata); o_cnt = 32'(bus_c.busy_cnt);
                     o_rdy = bus_c.rdy; o_wren = bus_c.wren; end
            default: begin o_addr = 32'(bus_d.addr); o_wrdata = 32'(bus_d.wrdata); o_cnt = 32'(bus_d.busy_cnt);
                     o_rdy = bus_d.rdy; o_wren = bus_d.wren; end
        endcase
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected write data: pattern at ADDR_W+1 bits, then cut to DATA_W.
    function automatic int expd(input int md, input int v, input int i);
        int m;
        int r;
        m = (1 << (aw_t[sel] + 1)) - 1;
        case (md)
            0:       r = i;
            1:       r = v & m;
            2:       r = dep_t[sel] - 1 - i;
            default: r = i ^ (v & m);
        endcase
        r = r & m;
        return r & ((1 << dw_t[sel]) - 1);
    endfunction

    // One sweep on the selected DUT. Options (negative/0 = off):
    //   sf..st : cycles after acceptance with stall high
    //   sl     : stall once on the final word
    //   enp    : cycle at which en is pulsed (with different mode/fill_val)
    //   hold   : keep en high through completion
    //   rst_at : assert rst during the cycle carrying this write index
    task automatic run_sweep(input int md, input int v, input int sf, input int st,
                             input bit sl, input int enp, input bit hold, input int rst_at);
        int  dep;
        int  widx;
        int  cyc;
        int  nst;
        bit  last_done;
        bit  s;
        dep = dep_t[sel];
        widx = 0; cyc = 1; nst = 0; last_done = 1'b0;
        check("pre_rdy", 32'(o_rdy), 32'd1);
        mode = 2'(md); fill_val = 8'(v); stall = 1'b0; en = 1'b1;
        tick();
        while (widx < dep && cyc <= dep + 16) begin
            s = ((cyc >= sf) && (cyc <= st)) || (sl && (widx == dep - 1) && !last_done);
            if (sl && (widx == dep - 1) && s) last_done = 1'b1;
            stall = s;
            en = hold || (cyc == enp);
            if (cyc == enp) begin mode = 2'(md + 1); fill_val = 8'h33; end
            #1;
            check("fill_rdy", 32'(o_rdy), 32'd0);
            check("fill_addr", o_addr, 32'(widx));
            check("fill_cnt", o_cnt, 32'(widx));
            if (s) begin
                nst++;
                check("stall_wren", 32'(o_wren), 32'd0);
            end else begin
                check("wren", 32'(o_wren), 32'd1);
                check("wrdata", o_wrdata, 32'(expd(md, v, widx)));
                cap[widx] = int'(o_wrdata);
                widx++;
                if (rst_at >= 0 && widx - 1 == rst_at) begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0; stall = 1'b0; en = 1'b0;
                    #1;
                    check("rst_rdy", 32'(o_rdy), 32'd1);
                    check("rst_wren", 32'(o_wren), 32'd0);
                    check("rst_cnt", o_cnt, 32'd0);
                    check("rst_addr", o_addr, 32'd0);
                    return;
                end
            end
            tick();
            cyc++;
        end
        stall = 1'b0;
        en = hold;
        #1;
        check("latency", 32'(cyc), 32'(dep + 1 + nst));
        check("done_rdy", 32'(o_rdy), 32'd1);
        check("done_wren", 32'(o_wren), 32'd0);
        check("done_cnt", o_cnt, 32'(dep));
        check("idle_addr", o_addr, 32'd0);
        check("idle_data", o_wrdata, 32'd0);
        if (hold) begin
            tick();
            check("rehold_rdy", 32'(o_rdy), 32'd0);
            check("rehold_addr", o_addr, 32'd0);
            check("rehold_wren", 32'(o_wren), 32'd1);
            check("rehold_cnt", o_cnt, 32'd0);
            tick();
            check("rehold_addr1", o_addr, 32'd1);
            en = 1'b0;
        end
        en = 1'b0;
    endtask

    initial begin
        // Reset values on every configuration.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            check("reset_rdy", 32'(o_rdy), 32'd1);
            check("reset_wren", 32'(o_wren), 32'd0);
            check("reset_addr", o_addr, 32'd0);
            check("reset_data", o_wrdata, 32'd0);
            check("reset_cnt", o_cnt, 32'd0);
        end
        sel = 0;
        tick();

        // Identity, constant, xor.
        run_sweep(0, 0, -1, -1, 1'b0, -1, 1'b0, -1);
        check("id_255", 32'(cap[255]), 32'hFF);
        run_sweep(1, 8'hA5, -1, -1, 1'b0, -1, 1'b0, -1);
        check("const_0", 32'(cap[0]), 32'hA5);
        check("const_255", 32'(cap[255]), 32'hA5);
        run_sweep(3, 8'h0F, -1, -1, 1'b0, -1, 1'b0, -1);
        check("xor_10", 32'(cap[16]), 32'h1F);
        check("xor_ff", 32'(cap[255]), 32'hF0);

        // Reverse with stalls at cycles 3-5 and on the final word.
        run_sweep(2, 0, 3, 5, 1'b1, -1, 1'b0, -1);
        check("rev_0", 32'(cap[0]), 32'hFF);
        check("rev_255", 32'(cap[255]), 32'h00);

        // en pulsed mid-sweep is ignored.
        run_sweep(0, 0, -1, -1, 1'b0, 50, 1'b0, -1);

        // en held across completion: one idle cycle, then a new sweep.
        tick();
        run_sweep(0, 0, -1, -1, 1'b0, -1, 1'b1, -1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_rdy", 32'(o_rdy), 32'd1);

        // rst and en on the same edge: rst wins.
        rst = 1'b1; en = 1'b1;
        tick();
        rst = 1'b0; en = 1'b0;
        check("rst_en_rdy", 32'(o_rdy), 32'd1);
        check("rst_en_wren", 32'(o_wren), 32'd0);

        // Reset at write 100, then a fresh full sweep.
        run_sweep(0, 0, -1, -1, 1'b0, -1, 1'b0, 100);
        tick();
        check("post_rst_wren", 32'(o_wren), 32'd0);
        run_sweep(0, 0, -1, -1, 1'b0, -1, 1'b0, -1);

        // Parameter corners.
        sel = 1;
        #1;
        run_sweep(0, 0, -1, -1, 1'b0, -1, 1'b0, -1);
        check("d10_last", 32'(cap[9]), 32'd9);
        sel = 2;
        #1;
        run_sweep(0, 0, -1, -1, 1'b0, -1, 1'b0, -1);
        sel = 3;
        #1;
        run_sweep(0, 0, -1, -1, 1'b0, -1, 1'b0, -1);
        check("narrow_1f", 32'(cap[31]), 32'hF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
